// File: rtl/alu_lock_server_pkg.sv
// alu_lock_server_pkg: shared ALU lock protocol types and the issue-ID age compare.
// Revision: 1.0
`default_nettype none

package alu_lock_server_pkg;

  localparam int ID_W = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_LUI  = 4'd10
  } alu_op_t;

  typedef struct packed {
    logic            req;
    logic [ID_W-1:0] req_issue_id;
    logic            release_lock;
  } alu_rpl_t;

  typedef struct packed {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  typedef struct packed {
    logic [31:0] c;
    logic        zero;
  } alu_ans_t;

  // Issue IDs wrap, so age is decided by the sign of the modular difference.
  function automatic logic is_older(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b);
    logic [ID_W-1:0] diff;
    diff = a - b;
    return diff[ID_W-1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_lock_server_alu_core.sv
// alu_core: purely combinational 32-bit integer ALU shared by all SICs.
// Revision: 1.0
`default_nettype none

module alu_core
  import alu_lock_server_pkg::*;
(
  input  alu_op_t     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] c_o,
  output logic        zero_o
);

  logic [4:0] w_shamt;
  assign w_shamt = b_i[4:0];

  always_comb begin
    c_o = 32'h0;
    case (op_i)
      OP_ADD:  c_o = a_i + b_i;
      OP_SUB:  c_o = a_i - b_i;
      OP_AND:  c_o = a_i & b_i;
      OP_OR:   c_o = a_i | b_i;
      OP_XOR:  c_o = a_i ^ b_i;
      OP_SLL:  c_o = a_i << w_shamt;
      OP_SRL:  c_o = a_i >> w_shamt;
      OP_SRA:  c_o = $unsigned($signed(a_i) >>> w_shamt);
      OP_SLT:  c_o = {31'h0, $signed(a_i) < $signed(b_i)};
      OP_SLTU: c_o = {31'h0, a_i < b_i};
      OP_LUI:  c_o = b_i << 16;
      default: c_o = 32'h0;
    endcase
  end

  assign zero_o = (c_o == 32'h0);

endmodule

`default_nettype wire

// File: rtl/alu_lock_server.sv
// alu_lock_server: age-ordered arbiter granting exclusive ownership of the shared ALU.
// Revision: 1.0
`default_nettype none

module alu_lock_server
  import alu_lock_server_pkg::*;
#(
  parameter int NUM_SICS = 4,
  parameter int ID_WIDTH = ID_W
) (
  input  logic                clk,
  input  logic                rst,
  input  alu_rpl_t            rpl     [NUM_SICS],
  input  alu_req_t            alu_req [NUM_SICS],
  output logic [NUM_SICS-1:0] alu_grant,
  output alu_ans_t            alu_ans
);

  localparam int OWNER_W = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;

  logic                 found;
  logic [OWNER_W-1:0]   winner;
  logic [ID_WIDTH-1:0]  best_id;
  logic                 owner_rel;
  logic [31:0]          core_c;
  logic                 core_zero;

  // Strictly-older test keeps the lower index on equal IDs.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    best_id = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      if (rpl[i].req && (!found || is_older(rpl[i].req_issue_id, best_id))) begin
        found   = 1'b1;
        winner  = OWNER_W'(i);
        best_id = rpl[i].req_issue_id;
      end
    end
  end

  assign owner_rel = (state_q == LOCKED) && rpl[owner_q].release_lock;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (state_q == IDLE || owner_rel) begin
      state_d = found ? LOCKED : IDLE;
      if (found) owner_d = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // In the release cycle the owner's req already belongs to its next instruction.
  generate
    for (genvar k = 0; k < NUM_SICS; k++) begin : g_grant
      assign alu_grant[k] = (state_q == LOCKED) && (owner_q == OWNER_W'(k))
                            && rpl[k].req && !owner_rel;
    end
  endgenerate

  alu_core u_alu_core (
    .op_i   (alu_req[owner_q].op),
    .a_i    (alu_req[owner_q].a),
    .b_i    (alu_req[owner_q].b),
    .c_o    (core_c),
    .zero_o (core_zero)
  );

  assign alu_ans = (|alu_grant) ? '{c: core_c, zero: core_zero} : '0;

endmodule

`default_nettype wire

// File: tb/tb_alu_lock_server.sv
// tb_alu_lock_server: directed checks of arbitration, handoff, abort and ALU results.
// Revision: 1.0
`default_nettype none

module tb_alu_lock_server;
  import alu_lock_server_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  alu_rpl_t  rpl  [4];
  alu_req_t  areq [4];
  logic [3:0] grant;
  alu_ans_t  ans;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_lock_server #(.NUM_SICS(4), .ID_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rpl       (rpl),
    .alu_req   (areq),
    .alu_grant (grant),
    .alu_ans   (ans)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      rpl[i]  = '0;
      areq[i] = '{op: OP_ADD, a: 32'h0, b: 32'h0};
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 3 units later.
  task automatic settle();
    #3;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    tick(); settle();
    chk("reset_grant", 64'(grant), 64'h0);
    chk("reset_ans", 64'(ans), 64'h0);

    // Single request
    rst = 1'b0;
    rpl[2] = '{req: 1'b1, req_issue_id: 8'd5, release_lock: 1'b0};
    areq[2] = '{op: OP_ADD, a: 32'd3, b: 32'd4};
    settle();
    chk("single_idle_grant", 64'(grant), 64'h0);
    tick(); settle();
    chk("single_grant", 64'(grant), 64'h4);
    chk("single_add_c", 64'(ans.c), 64'd7);
    chk("single_add_zero", 64'(ans.zero), 64'h0);
    tick();
    rpl[2] = '{req: 1'b0, req_issue_id: 8'd5, release_lock: 1'b1};
    settle();
    chk("single_release_grant", 64'(grant), 64'h0);
    tick();
    clr();
    settle();
    chk("single_idle_after", 64'(grant), 64'h0);

    // Age priority and back-to-back handoff
    rpl[0] = '{req: 1'b1, req_issue_id: 8'd9, release_lock: 1'b0};
    rpl[3] = '{req: 1'b1, req_issue_id: 8'd7, release_lock: 1'b0};
    areq[3] = '{op: OP_SUB, a: 32'd5, b: 32'd5};
    areq[0] = '{op: OP_LUI, a: 32'd0, b: 32'h1234};
    tick(); settle();
    chk("age_grant", 64'(grant), 64'h8);
    chk("sub_c", 64'(ans.c), 64'h0);
    chk("sub_zero", 64'(ans.zero), 64'h1);
    tick();
    rpl[3] = '{req: 1'b0, req_issue_id: 8'd7, release_lock: 1'b1};
    settle();
    chk("handoff_release_grant", 64'(grant), 64'h0);
    chk("handoff_release_ans", 64'(ans), 64'h0);
    tick();
    rpl[3] = '0;
    settle();
    chk("handoff_new_grant", 64'(grant), 64'h1);
    chk("lui_c", 64'(ans.c), 64'h1234_0000);
    tick();
    rpl[0] = '{req: 1'b0, req_issue_id: 8'd9, release_lock: 1'b1};
    tick();
    clr();
    settle();
    chk("age_idle", 64'(grant), 64'h0);

    // Wrap-around, then abort by the owner
    rpl[1] = '{req: 1'b1, req_issue_id: 8'hFE, release_lock: 1'b0};
    rpl[2] = '{req: 1'b1, req_issue_id: 8'h01, release_lock: 1'b0};
    tick(); settle();
    chk("wrap_grant", 64'(grant), 64'h2);
    rpl[2] = '0;
    rpl[0] = '{req: 1'b1, req_issue_id: 8'd3, release_lock: 1'b0};
    tick();
    rpl[1].req = 1'b0;
    settle();
    chk("abort_grant", 64'(grant), 64'h0);
    tick(); settle();
    chk("abort_held", 64'(grant), 64'h0);
    tick();
    rpl[1].release_lock = 1'b1;
    settle();
    chk("abort_release_grant", 64'(grant), 64'h0);
    tick();
    rpl[1] = '0;
    settle();
    chk("abort_next_grant", 64'(grant), 64'h1);

    // Stray release from a non-owner while SIC0 owns the lock
    areq[0] = '{op: OP_SLT, a: 32'hFFFF_FFFF, b: 32'd1};
    rpl[3].release_lock = 1'b1;
    settle();
    chk("stray_grant", 64'(grant), 64'h1);
    chk("slt_c", 64'(ans.c), 64'h1);
    tick();
    rpl[3] = '0;
    areq[0] = '{op: OP_SLTU, a: 32'hFFFF_FFFF, b: 32'd1};
    settle();
    chk("stray_held", 64'(grant), 64'h1);
    chk("sltu_c", 64'(ans.c), 64'h0);
    chk("sltu_zero", 64'(ans.zero), 64'h1);
    rpl[2] = '{req: 1'b1, req_issue_id: 8'd20, release_lock: 1'b0};
    areq[2] = '{op: OP_SRA, a: 32'h8000_0000, b: 32'h24};
    tick();
    rpl[0] = '{req: 1'b0, req_issue_id: 8'd3, release_lock: 1'b1};
    tick();
    rpl[0] = '0;
    settle();
    chk("stray_handoff_grant", 64'(grant), 64'h4);
    chk("sra_c", 64'(ans.c), 64'hF800_0000);

    // Reset while LOCKED(2)
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rpl[2] = '0;
    settle();
    chk("rst_mid_grant", 64'(grant), 64'h0);
    chk("rst_mid_ans", 64'(ans), 64'h0);
    tick(); settle();
    chk("rst_mid_idle", 64'(grant), 64'h0);
    rpl[2] = '{req: 1'b1, req_issue_id: 8'd40, release_lock: 1'b0};
    areq[2] = '{op: OP_ADD, a: 32'hFFFF_FFFF, b: 32'd2};
    tick(); settle();
    chk("rst_new_grant", 64'(grant), 64'h4);
    chk("add_wrap_c", 64'(ans.c), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
